// File: rtl/seg_display_scan.sv
// Eight-digit multiplexed 7-segment driver with a 32-cycle double-dabble binary-to-BCD converter.
// Optional leading-zero blanking is enabled by defining SEG_LEADING_BLANK_EN.
module seg_display_scan #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] value_in,
    output logic [6:0]  seg_n,
    output logic [7:0]  an_n,
    output logic [31:0] bcd,
    output logic        ovf,
    output logic        busy
);

    localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(SCAN_DIV - 1);

    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_t;

    conv_state_t state, state_next;

    logic [31:0] last_val;
    logic [39:0] work_bcd;
    logic [31:0] work_bin;
    logic [4:0]  iter_cnt;

    logic [PW-1:0] prescale;
    logic [2:0]    scan_idx;
    logic [3:0]    cur_digit;
    logic [6:0]    seg_next;

    // Add 3 to every digit >= 5 so the following left shift carries correctly into the next digit.
    function automatic logic [39:0] dd_adjust(input logic [39:0] d);
        logic [39:0] r;
        r = d;
        for (int unsigned i = 0; i < 10; i++) begin
            if (r[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (value_in != last_val) state_next = CONV;
            CONV:    if (iter_cnt == 5'd31)    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_val <= '0;
            work_bcd <= '0;
            work_bin <= '0;
            iter_cnt <= '0;
            busy     <= 1'b0;
            bcd      <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (value_in != last_val) begin
                        last_val <= value_in;
                        work_bin <= value_in;
                        work_bcd <= '0;
                        iter_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                CONV: begin
                    {work_bcd, work_bin} <= {dd_adjust(work_bcd), work_bin} << 1;
                    iter_cnt <= iter_cnt + 5'd1;
                end
                DONE: begin
                    bcd  <= work_bcd[31:0];
                    ovf  <= |work_bcd[39:32];
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            prescale <= '0;
            scan_idx <= '0;
        end else if (prescale == PS_MAX) begin
            prescale <= '0;
            scan_idx <= scan_idx + 3'd1;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

    assign cur_digit = bcd[{scan_idx, 2'b00} +: 4];

`ifdef SEG_LEADING_BLANK_EN
    logic [2:0] msd_idx;

    // Highest nonzero digit; stays 0 for an all-zero value so digit0 always shows.
    always_comb begin
        msd_idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (bcd[4*i +: 4] != 4'd0)
                msd_idx = 3'(i);
        end
    end

    always_comb begin
        seg_next = seg_encode(cur_digit);
        if (ovf)
            seg_next = SEG_E;
        else if (scan_idx > msd_idx)
            seg_next = SEG_BLANK;
    end
`else
    always_comb begin
        seg_next = seg_encode(cur_digit);
        if (ovf)
            seg_next = SEG_E;
    end
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            an_n  <= '1;
            seg_n <= SEG_BLANK;
        end else begin
            an_n  <= ~(8'd1 << scan_idx);
            seg_n <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan with SCAN_DIV=4; leading-blank expectations follow SEG_LEADING_BLANK_EN.
module tb_seg_display_scan;

    localparam int SCAN_DIV = 4;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] value_in = '0;
    logic [6:0]  seg_n;
    logic [7:0]  an_n;
    logic [31:0] bcd;
    logic        ovf;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    seg_display_scan #(.SCAN_DIV(SCAN_DIV)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .value_in(value_in),
        .seg_n   (seg_n),
        .an_n    (an_n),
        .bcd     (bcd),
        .ovf     (ovf),
        .busy    (busy)
    );

    // Advance to the next negedge where digit d is enabled; found=0 if it never appears.
    task automatic wait_slot(input int d, output bit found);
        logic [7:0] pat;
        pat = ~(8'd1 << d);
        found = 1'b0;
        for (int g = 0; g < 64 && !found; g++) begin
            @(negedge clock);
            if (an_n === pat) found = 1'b1;
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        value_in = '0;
        repeat (3) @(negedge clock);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (bcd !== 32'h0) begin n_bad++; $display("FAIL reset_bcd got=%h want=00000000", bcd); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
        n_cmp++; if (an_n !== 8'hFF) begin n_bad++; $display("FAIL reset_an got=%h want=ff", an_n); end
        n_cmp++; if (seg_n !== 7'h7F) begin n_bad++; $display("FAIL reset_seg got=%h want=7f", seg_n); end
    endtask

    task automatic test_scan;
        logic [7:0] exp_an;
        resetn = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clock);
            exp_an = ~(8'd1 << (((k - 1) / 4) % 8));
            n_cmp++;
            if (an_n !== exp_an) begin n_bad++; $display("FAIL scan_an k=%0d got=%h want=%h", k, an_n, exp_an); end
            n_cmp++;
            if (seg_n !== 7'h40) begin n_bad++; $display("FAIL scan_seg k=%0d got=%h want=40", k, seg_n); end
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL scan_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_convert;
        int cnt;
        bit found;
        value_in = 32'd12345678;
        @(negedge clock);
        cnt = 0;
        for (int g = 0; g < 100 && busy === 1'b1; g++) begin
            cnt++;
            @(negedge clock);
        end
        n_cmp++; if (cnt != 33) begin n_bad++; $display("FAIL conv_busy_len got=%0d want=33", cnt); end
        n_cmp++; if (bcd !== 32'h12345678) begin n_bad++; $display("FAIL conv_bcd got=%h want=12345678", bcd); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL conv_ovf got=%b want=0", ovf); end
        @(negedge clock);
        wait_slot(0, found);
        n_cmp++;
        if (!found || seg_n !== 7'h00) begin n_bad++; $display("FAIL conv_dig0 found=%b got=%h want=00", found, seg_n); end
        wait_slot(7, found);
        n_cmp++;
        if (!found || seg_n !== 7'h79) begin n_bad++; $display("FAIL conv_dig7 found=%b got=%h want=79", found, seg_n); end
        wait_slot(4, found);
        n_cmp++;
        if (!found || seg_n !== 7'h19) begin n_bad++; $display("FAIL conv_dig4 found=%b got=%h want=19", found, seg_n); end
    endtask

    task automatic test_overflow;
        int cnt;
        bit found;
        value_in = 32'd100000000;
        @(negedge clock);
        cnt = 0;
        for (int g = 0; g < 100 && busy === 1'b1; g++) begin
            cnt++;
            @(negedge clock);
        end
        n_cmp++; if (cnt != 33) begin n_bad++; $display("FAIL ovf_busy_len got=%0d want=33", cnt); end
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got=%b want=1", ovf); end
        n_cmp++; if (bcd !== 32'h0) begin n_bad++; $display("FAIL ovf_bcd got=%h want=00000000", bcd); end
        @(negedge clock);
        for (int d = 0; d < 8; d++) begin
            wait_slot(d, found);
            n_cmp++;
            if (!found || seg_n !== 7'h06) begin n_bad++; $display("FAIL ovf_dig%0d found=%b got=%h want=06", d, found, seg_n); end
        end
    endtask

    task automatic test_back_to_back;
        int cnt;
        value_in = 32'd5;
        @(negedge clock);
        cnt = 0;
        for (int g = 0; g < 100 && busy === 1'b1; g++) begin
            cnt++;
            if (cnt == 10) value_in = 32'd7;
            @(negedge clock);
        end
        n_cmp++; if (cnt != 33) begin n_bad++; $display("FAIL b2b_first_len got=%0d want=33", cnt); end
        n_cmp++; if (bcd !== 32'h5) begin n_bad++; $display("FAIL b2b_first_bcd got=%h want=00000005", bcd); end
        @(negedge clock);
        cnt = 0;
        for (int g = 0; g < 100 && busy === 1'b1; g++) begin
            cnt++;
            @(negedge clock);
        end
        n_cmp++; if (cnt != 33) begin n_bad++; $display("FAIL b2b_second_len got=%0d want=33", cnt); end
        n_cmp++; if (bcd !== 32'h7) begin n_bad++; $display("FAIL b2b_second_bcd got=%h want=00000007", bcd); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL b2b_ovf got=%b want=0", ovf); end
    endtask

    task automatic test_reset_mid_conv;
        value_in = 32'd999;
        @(negedge clock);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmc_start_busy got=%b want=1", busy); end
        repeat (19) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmc_async_busy got=%b want=0", busy); end
        n_cmp++; if (bcd !== 32'h0) begin n_bad++; $display("FAIL rmc_async_bcd got=%h want=00000000", bcd); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL rmc_async_ovf got=%b want=0", ovf); end
        @(negedge clock);
        resetn = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clock);
            if (k == 1) begin
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmc_restart_busy got=%b want=1", busy); end
            end
            if (k == 33) begin
                n_cmp++; if (bcd !== 32'h0) begin n_bad++; $display("FAIL rmc_bcd_early got=%h want=00000000", bcd); end
            end
            if (k == 34) begin
                n_cmp++; if (bcd !== 32'h00000999) begin n_bad++; $display("FAIL rmc_bcd got=%h want=00000999", bcd); end
            end
        end
    endtask

    task automatic test_leading;
        int cnt;
        bit found;
        logic [6:0] exp_hi;
`ifdef SEG_LEADING_BLANK_EN
        exp_hi = 7'h7F;
`else
        exp_hi = 7'h40;
`endif
        value_in = 32'd42;
        @(negedge clock);
        cnt = 0;
        for (int g = 0; g < 100 && busy === 1'b1; g++) begin
            cnt++;
            @(negedge clock);
        end
        n_cmp++; if (bcd !== 32'h42) begin n_bad++; $display("FAIL lead_bcd got=%h want=00000042", bcd); end
        @(negedge clock);
        wait_slot(0, found);
        n_cmp++;
        if (!found || seg_n !== 7'h24) begin n_bad++; $display("FAIL lead_dig0 found=%b got=%h want=24", found, seg_n); end
        wait_slot(1, found);
        n_cmp++;
        if (!found || seg_n !== 7'h19) begin n_bad++; $display("FAIL lead_dig1 found=%b got=%h want=19", found, seg_n); end
        for (int d = 2; d < 8; d++) begin
            wait_slot(d, found);
            n_cmp++;
            if (!found || seg_n !== exp_hi) begin n_bad++; $display("FAIL lead_dig%0d found=%b got=%h want=%h", d, found, seg_n, exp_hi); end
        end
    endtask

    initial begin
        test_reset;
        test_scan;
        test_convert;
        test_overflow;
        test_back_to_back;
        test_reset_mid_conv;
        test_leading;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
